// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the traffic phase scheduler: FSM state encoding, phase
// (owner) encoding, lamp vector width and small combinational helpers.
// Optional feature macro used by this slice: EMERGENCY_PREEMPT_EN.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_WALK    = 2'd3
  } state_e;

  localparam logic [1:0] PH_ROAD1 = 2'd0;
  localparam logic [1:0] PH_ROAD2 = 2'd1;
  localparam logic [1:0] PH_ROAD3 = 2'd2;
  localparam logic [1:0] PH_PED   = 2'd3;

  localparam int LAMP_W = 3;

  typedef struct packed {
    logic [LAMP_W-1:0] green;
    logic [LAMP_W-1:0] yellow;
    logic [LAMP_W-1:0] red;
    logic              walk;
    logic              dont_walk;
  } lamps_t;

  // One-hot mask of a phase owner over the four request lines.
  function automatic logic [3:0] ph_onehot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

  // Round-robin pick over pend starting at (ph+1) mod 4; the owner itself is
  // searched last. Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] ph);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ph + 2'(k);
      if (pend[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Lamp pattern for a given state/owner; anything that is not a valid
  // green/yellow/walk owner falls back to all-red, dont_walk.
  function automatic lamps_t lamps_for(input state_e st, input logic [1:0] ph);
    lamps_t            l;
    logic [3:0]        oh;
    oh          = ph_onehot(ph);
    l.green     = {LAMP_W{1'b0}};
    l.yellow    = {LAMP_W{1'b0}};
    l.red       = {LAMP_W{1'b1}};
    l.walk      = 1'b0;
    l.dont_walk = 1'b1;
    case (st)
      ST_GREEN: begin
        l.green = oh[LAMP_W-1:0];
        l.red   = ~oh[LAMP_W-1:0];
      end
      ST_YELLOW: begin
        l.yellow = oh[LAMP_W-1:0];
        l.red    = ~oh[LAMP_W-1:0];
      end
      ST_WALK: begin
        l.walk      = 1'b1;
        l.dont_walk = 1'b0;
      end
      default: begin
        l.walk      = 1'b0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Bus between the traffic phase scheduler and its environment: timebase,
// requests, acks, lamps and status. The emergency pair exists only when
// EMERGENCY_PREEMPT_EN is defined.
interface traffic_phase_scheduler_if;
  import traffic_pkg::*;

  logic              tick;
  logic [3:0]        req;
  logic [3:0]        ack;
  logic [LAMP_W-1:0] green;
  logic [LAMP_W-1:0] yellow;
  logic [LAMP_W-1:0] red;
  logic              walk;
  logic              dont_walk;
  logic [1:0]        phase;
  logic [1:0]        state_o;
`ifdef EMERGENCY_PREEMPT_EN
  logic              emg_req;
  logic [1:0]        emg_road;
`endif

  modport master (
`ifdef EMERGENCY_PREEMPT_EN
    output emg_req, output emg_road,
`endif
    output tick, output req,
    input  ack, input green, input yellow, input red,
    input  walk, input dont_walk, input phase, input state_o
  );

  modport slave (
`ifdef EMERGENCY_PREEMPT_EN
    input  emg_req, input emg_road,
`endif
    input  tick, input req,
    output ack, output green, output yellow, output red,
    output walk, output dont_walk, output phase, output state_o
  );

endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase timer: counts ticks since the last clear and holds at LIMIT.
module phase_timer #(
  parameter int LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_clr,
  output logic [3:0] o_count
);

  logic [3:0] r_count;

  // Clear dominates; otherwise advance on tick until the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 4'd0;
    end else if (i_clr) begin
      r_count <= 4'd0;
    end else if (i_tick && (r_count < 4'(LIMIT))) begin
      r_count <= r_count + 4'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: three roads plus a pedestrian phase served
// round-robin, with minimum/maximum green, yellow and walk intervals.
// Optional emergency preemption is compiled in with EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int WALK_T    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_scheduler_if.slave  bus
);

  state_e     r_state;
  logic [1:0] r_phase;
  logic [3:0] r_pend;
  logic [3:0] r_ack;
  lamps_t     r_lamps;

  state_e     w_next_state;
  logic [1:0] w_next_phase;
  logic [3:0] w_grant;
  logic [3:0] w_count;
  logic [4:0] w_t_inc;
  logic [2:0] w_pick;
  logic       w_rival;
  logic       w_state_chg;

  phase_timer #(.LIMIT(GREEN_MAX)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (bus.tick),
    .i_clr   (w_state_chg),
    .o_count (w_count)
  );

  // Next state, next owner and grant mask; w_t_inc is the tick count
  // including the current tick, so an interval of N ends on its N-th tick.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_grant      = 4'b0000;
    w_pick       = rr_pick(r_pend, r_phase);
    w_t_inc      = {1'b0, w_count} + 5'd1;
    w_rival      = |(r_pend & ~ph_onehot(r_phase));
    case (r_state)
      ST_ALL_RED: begin
        if (!bus.tick) begin
          w_next_state = ST_ALL_RED;
        end
`ifdef EMERGENCY_PREEMPT_EN
        else if (bus.emg_req) begin
          w_next_state = ST_GREEN;
          w_next_phase = bus.emg_road;
          w_grant      = r_pend & ph_onehot(bus.emg_road);
        end
`endif
        else if (w_pick[2]) begin
          w_next_phase = w_pick[1:0];
          w_grant      = ph_onehot(w_pick[1:0]);
          w_next_state = (w_pick[1:0] == PH_PED) ? ST_WALK : ST_GREEN;
        end else begin
          // Nothing pending: rotate to the next road, pedestrian wraps to road 1.
          w_next_state = ST_GREEN;
          w_next_phase = ((r_phase == PH_ROAD3) || (r_phase == PH_PED)) ? PH_ROAD1 : (r_phase + 2'd1);
        end
      end
      ST_GREEN: begin
        if (!bus.tick) begin
          w_next_state = ST_GREEN;
        end
`ifdef EMERGENCY_PREEMPT_EN
        else if (bus.emg_req) begin
          w_next_state = (r_phase != bus.emg_road) ? ST_YELLOW : ST_GREEN;
        end
`endif
        else if (w_rival && ((w_t_inc >= 5'(GREEN_MIN)) || (w_count == 4'(GREEN_MAX)))) begin
          w_next_state = ST_YELLOW;
        end else begin
          w_next_state = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (bus.tick && (w_t_inc >= 5'(YELLOW_T))) begin
          w_next_state = ST_ALL_RED;
        end else begin
          w_next_state = ST_YELLOW;
        end
      end
      ST_WALK: begin
        if (!bus.tick) begin
          w_next_state = ST_WALK;
        end
`ifdef EMERGENCY_PREEMPT_EN
        else if (bus.emg_req) begin
          w_next_state = ST_ALL_RED;
        end
`endif
        else if (w_t_inc >= 5'(WALK_T)) begin
          w_next_state = ST_ALL_RED;
        end else begin
          w_next_state = ST_WALK;
        end
      end
      default: begin
        w_next_state = ST_ALL_RED;
      end
    endcase
    w_state_chg = (w_next_state != r_state);
  end

  // FSM state, owner, pending latch, ack pulse and lamps, all registered
  // together so lamps change in the same cycle as the state. A pending bit
  // is cleared in the cycle its ack is visible, overriding a same-cycle req.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_ALL_RED;
      r_phase <= PH_PED;
      r_pend  <= 4'b0000;
      r_ack   <= 4'b0000;
      r_lamps <= lamps_for(ST_ALL_RED, PH_PED);
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_pend  <= (r_pend | bus.req) & ~r_ack;
      r_ack   <= w_grant;
      r_lamps <= lamps_for(w_next_state, w_next_phase);
    end
  end

  assign bus.ack       = r_ack;
  assign bus.green     = r_lamps.green;
  assign bus.yellow    = r_lamps.yellow;
  assign bus.red       = r_lamps.red;
  assign bus.walk      = r_lamps.walk;
  assign bus.dont_walk = r_lamps.dont_walk;
  assign bus.phase     = r_phase;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler (default parameters 4/12/3/6).
// Also exercises emergency preemption when EMERGENCY_PREEMPT_EN is defined.
module tb_traffic_phase_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lamp safety: one lamp per road, at most one road non-red, walk => all red.
  task automatic lamp_inv();
    logic ok;
    int   nonred;
    ok     = 1'b1;
    nonred = 0;
    for (int i = 0; i < 3; i++) begin
      if ($countones({bus.green[i], bus.yellow[i], bus.red[i]}) != 1) ok = 1'b0;
      if (bus.red[i] !== 1'b1) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    if (bus.walk && (bus.red !== 3'b111)) ok = 1'b0;
    if (bus.walk === bus.dont_walk) ok = 1'b0;
    chk("lamp_invariant", 32'(ok), 32'd1);
  endtask

  task automatic step(input logic t, input logic [3:0] r);
    bus.tick = t;
    bus.req  = r;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    lamp_inv();
  endtask

  // Tick every cycle until state_o leaves st (bounded); check dwell length.
  task automatic measure(input string tag, input logic [1:0] st, input logic [1:0] ph,
                         input int len, input logic [3:0] r);
    int n;
    n = 0;
    chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
    chk({tag, "_phase"}, 32'(bus.phase), 32'(ph));
    while ((bus.state_o == st) && (n < 20)) begin
      step(1'b1, r);
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(len));
  endtask

  initial begin
    rst      = 1'b0;
    bus.tick = 1'b0;
    bus.req  = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
    bus.emg_req  = 1'b0;
    bus.emg_road = 2'd0;
`endif
    // Reset, with tick and requests present that must be ignored
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0101);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_red", 32'(bus.red), 32'h7);
    chk("rst_green", 32'(bus.green), 32'h0);
    chk("rst_yellow", 32'(bus.yellow), 32'h0);
    chk("rst_walk", 32'(bus.walk), 32'd0);
    chk("rst_dont_walk", 32'(bus.dont_walk), 32'd1);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_phase", 32'(bus.phase), 32'd3);
    chk("rst_pend", 32'(dut.r_pend), 32'h0);

    // Release with nothing pending: one ALL_RED tick, then road 0 green, no ack
    rst = 1'b1;
    step(1'b0, 4'b0000);
    chk("idle_no_tick_state", 32'(bus.state_o), 32'd0);
    step(1'b1, 4'b0000);
    chk("idle_state", 32'(bus.state_o), 32'd1);
    chk("idle_green", 32'(bus.green), 32'h1);
    chk("idle_red", 32'(bus.red), 32'h6);
    chk("idle_phase", 32'(bus.phase), 32'd0);
    chk("idle_ack", 32'(bus.ack), 32'h0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 4'b0000);
      chk("rest_green_state", 32'(bus.state_o), 32'd1);
    end
    chk("rest_green_lamp", 32'(bus.green), 32'h1);

    // Competitor on road 1 after a long rest: yellow on the very next tick
    step(1'b0, 4'b0010);
    step(1'b1, 4'b0000);
    chk("y0_state", 32'(bus.state_o), 32'd2);
    chk("y0_yellow", 32'(bus.yellow), 32'h1);
    chk("y0_green", 32'(bus.green), 32'h0);
    measure("y0", 2'd2, 2'd0, 3, 4'b0000);
    measure("ar_to1", 2'd0, 2'd0, 1, 4'b0000);
    chk("g1_green", 32'(bus.green), 32'h2);
    chk("g1_ack", 32'(bus.ack), 32'h2);
    step(1'b0, 4'b0000);
    chk("g1_ack_drop", 32'(bus.ack), 32'h0);
    chk("g1_pend_clr", 32'(dut.r_pend), 32'h0);

    // Road 2 request at T=1 of road 1 green: green holds until T=4
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    measure("g1_min", 2'd1, 2'd1, 3, 4'b0000);
    chk("y1_yellow", 32'(bus.yellow), 32'h2);
    measure("y1", 2'd2, 2'd1, 3, 4'b0000);
    measure("ar_to2", 2'd0, 2'd1, 1, 4'b0000);
    chk("g2_green", 32'(bus.green), 32'h4);
    chk("g2_ack", 32'(bus.ack), 32'h4);
    step(1'b0, 4'b0000);
    chk("g2_ack_once", 32'(bus.ack), 32'h0);

    // Reset in the middle of yellow
    measure("g2", 2'd1, 2'd2, 4, 4'b0001);
    step(1'b1, 4'b0001);
    chk("mid_y_state", 32'(bus.state_o), 32'd2);
    rst = 1'b0;
    step(1'b1, 4'b0001);
    chk("rst_y_state", 32'(bus.state_o), 32'd0);
    chk("rst_y_red", 32'(bus.red), 32'h7);
    chk("rst_y_yellow", 32'(bus.yellow), 32'h0);
    chk("rst_y_dont_walk", 32'(bus.dont_walk), 32'd1);
    chk("rst_y_pend", 32'(dut.r_pend), 32'h0);
    chk("rst_y_phase", 32'(bus.phase), 32'd3);
    step(1'b1, 4'b0001);
    chk("rst_tick_ignored", 32'(bus.state_o), 32'd0);

    // All requests held: order 0,1,2,PED,0
    rst = 1'b1;
    step(1'b0, 4'b1111);
    measure("rr_ar3", 2'd0, 2'd3, 1, 4'b1111);
    chk("rr_ack0", 32'(bus.ack), 32'h1);
    measure("rr_g0", 2'd1, 2'd0, 4, 4'b1111);
    measure("rr_y0", 2'd2, 2'd0, 3, 4'b1111);
    measure("rr_ar0", 2'd0, 2'd0, 1, 4'b1111);
    chk("rr_ack1", 32'(bus.ack), 32'h2);
    measure("rr_g1", 2'd1, 2'd1, 4, 4'b1111);
    measure("rr_y1", 2'd2, 2'd1, 3, 4'b1111);
    measure("rr_ar1", 2'd0, 2'd1, 1, 4'b1111);
    chk("rr_ack2", 32'(bus.ack), 32'h4);
    measure("rr_g2", 2'd1, 2'd2, 4, 4'b1111);
    measure("rr_y2", 2'd2, 2'd2, 3, 4'b1111);
    measure("rr_ar2", 2'd0, 2'd2, 1, 4'b1111);
    chk("rr_ack3", 32'(bus.ack), 32'h8);
    chk("rr_walk", 32'(bus.walk), 32'd1);
    chk("rr_walk_red", 32'(bus.red), 32'h7);
    measure("rr_walk", 2'd3, 2'd3, 6, 4'b1111);
    measure("rr_ar_ped", 2'd0, 2'd3, 1, 4'b1111);
    chk("rr_wrap_ack0", 32'(bus.ack), 32'h1);
    chk("rr_wrap_green", 32'(bus.green), 32'h1);

    // Pedestrian request coinciding with its ack is dropped, one more cycle re-latches
    rst = 1'b0;
    step(1'b0, 4'b0000);
    rst = 1'b1;
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    measure("ped_g0", 2'd1, 2'd0, 4, 4'b0000);
    measure("ped_y0", 2'd2, 2'd0, 3, 4'b0000);
    measure("ped_ar", 2'd0, 2'd0, 1, 4'b0000);
    chk("ped_ack", 32'(bus.ack), 32'h8);
    chk("ped_state", 32'(bus.state_o), 32'd3);
    step(1'b0, 4'b1000);
    chk("ped_same_cycle_pend", 32'(dut.r_pend[3]), 32'd0);
    chk("ped_ack_drop", 32'(bus.ack), 32'h0);
    step(1'b0, 4'b1000);
    chk("ped_relatch_pend", 32'(dut.r_pend[3]), 32'd1);
    measure("ped_walk", 2'd3, 2'd3, 6, 4'b0000);
    measure("ped_ar2", 2'd0, 2'd3, 1, 4'b0000);
    chk("ped_again_ack", 32'(bus.ack), 32'h8);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency on road 2 during road 0 green at T=1
    rst = 1'b0;
    step(1'b0, 4'b0000);
    rst = 1'b1;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    bus.emg_req  = 1'b1;
    bus.emg_road = 2'd2;
    step(1'b1, 4'b0000);
    chk("emg_yellow_state", 32'(bus.state_o), 32'd2);
    measure("emg_y0", 2'd2, 2'd0, 3, 4'b0000);
    step(1'b1, 4'b0000);
    chk("emg_green", 32'(bus.green), 32'h4);
    chk("emg_no_ack", 32'(bus.ack), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0001);
      chk("emg_hold", 32'(bus.green), 32'h4);
    end
    bus.emg_req = 1'b0;
    step(1'b1, 4'b0001);
    chk("emg_release_yellow", 32'(bus.state_o), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
